msg_sched: RTL and testbench

MSG_SCHED -- requirements
Module: msg_sched

---
 rtl/sha256_pkg.sv | 72 +++++++
 rtl/msg_sched_if.sv | 24 ++
 rtl/msg_sched.sv | 73 +++++++
 tb/tb_msg_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, schedule/compression helper functions,
// round constants and the message-schedule FSM state encoding.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int SCHED_LEN   = 64;
  localparam int BLOCK_WORDS = 16;
  localparam int IDX_W       = 7;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_HOLD
  } sched_state_t;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Round constant table K[0..63]
  function automatic word_t k_const(input logic [5:0] idx);
    word_t k;
    k = '0;
    case (idx)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/msg_sched_if.sv
// Block-in / schedule-out handshake bundle between the message source,
// the schedule expander and the compression stage.
interface msg_sched_if;
  import sha256_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  word_t [0:BLOCK_WORDS-1]     block_in;
  word_t [0:SCHED_LEN-1]       W;
  logic                        w_valid;
  logic                        w_ready;
  logic                        busy;

  modport master (
    output in_valid, block_in, w_ready,
    input  in_ready, W, w_valid, busy
  );

  modport slave (
    input  in_valid, block_in, w_ready,
    output in_ready, W, w_valid, busy
  );

endinterface

// File: rtl/msg_sched.sv
// SHA-256 message schedule expander: loads a 16-word block, computes W16..W63
// one word per cycle, then holds the full 64-word schedule until taken.
module msg_sched
  import sha256_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  msg_sched_if.slave bus
);

  localparam logic [IDX_W-1:0] FIRST_T = IDX_W'(BLOCK_WORDS);
  localparam logic [IDX_W-1:0] LAST_T  = IDX_W'(SCHED_LEN - 1);

  sched_state_t          state_q, state_d;
  logic [IDX_W-1:0]      t_q, t_d;
  word_t [0:SCHED_LEN-1] w_q, w_d;

  logic [5:0] idx;
  word_t      w_new;

  assign idx = t_q[5:0];

  // Single four-operand adder; index arithmetic wraps harmlessly outside EXPAND.
  assign w_new = sigma1(w_q[idx - 6'd2]) + w_q[idx - 6'd7]
               + sigma0(w_q[idx - 6'd15]) + w_q[idx - 6'd16];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    w_d     = w_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_d[0:BLOCK_WORDS-1] = bus.block_in;
          t_d                  = FIRST_T;
          state_d              = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        w_d[idx] = w_new;
        if (t_q == LAST_T) begin
          state_d = ST_HOLD;
        end else begin
          t_d = t_q + IDX_W'(1);
        end
      end
      ST_HOLD: begin
        if (bus.w_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      w_q     <= w_d;
    end
  end

  assign bus.in_ready = (state_q == ST_IDLE);
  assign bus.busy     = (state_q == ST_EXPAND);
  assign bus.w_valid  = (state_q == ST_HOLD);
  assign bus.W        = w_q;

endmodule

// File: tb/tb_msg_sched.sv
// Directed and random-stream bench for the SHA-256 message schedule expander.
module tb_msg_sched;

  typedef logic [0:15][31:0] blk_t;
  typedef logic [0:63][31:0] sched_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  msg_sched_if bus ();

  msg_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic sched_t model(input blk_t b);
    sched_t w;
    logic [31:0] s0, s1;
    w = '0;
    for (int i = 0; i < 16; i++) w[i] = b[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    return w;
  endfunction

  function automatic int first_diff(input sched_t a, input sched_t b);
    for (int i = 0; i < 64; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = $urandom;
    return b;
  endfunction

  function automatic blk_t abc_blk();
    blk_t b;
    b = '0;
    b[0]  = 32'h61626380;
    b[15] = 32'h00000018;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_block(input blk_t b);
    bus.block_in = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_hold(output int cyc);
    cyc = 0;
    while (bus.w_valid !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic handoff();
    bus.w_ready = 1'b1;
    tick();
    bus.w_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.w_valid !== 1'b0) begin n_bad++; $display("FAIL rst_w_valid: got %b want 0", bus.w_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.W !== '0) begin n_bad++; $display("FAIL rst_W: word %0d nonzero", first_diff(bus.W, '0)); end
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_idle_hold: in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_abc();
    sched_t want;
    int cyc;
    want = model(abc_blk());
    accept_block(abc_blk());
    n_cmp++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL abc_accept: busy=%b in_ready=%b want 1/0", bus.busy, bus.in_ready); end
    wait_hold(cyc);
    n_cmp++; if (cyc != 48) begin n_bad++; $display("FAIL abc_latency: got %0d want 48", cyc); end
    n_cmp++; if (bus.W[16] !== 32'h61626380) begin n_bad++; $display("FAIL abc_W16: got %h want 61626380", bus.W[16]); end
    n_cmp++; if (bus.W[17] !== 32'h000F0000) begin n_bad++; $display("FAIL abc_W17: got %h want 000f0000", bus.W[17]); end
    n_cmp++; if (bus.W[63] !== 32'h12B1EDEB) begin n_bad++; $display("FAIL abc_W63: got %h want 12b1edeb", bus.W[63]); end
    n_cmp++; if (bus.W !== want) begin n_bad++; $display("FAIL abc_sched: word %0d got %h want %h", first_diff(bus.W, want), bus.W[first_diff(bus.W, want)], want[first_diff(bus.W, want)]); end
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL abc_hold_flags: in_ready=%b busy=%b want 0/0", bus.in_ready, bus.busy); end
    handoff();
    n_cmp++; if (bus.w_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL abc_handoff: w_valid=%b in_ready=%b want 0/1", bus.w_valid, bus.in_ready); end
  endtask

  task automatic test_zero();
    int cyc;
    accept_block('0);
    wait_hold(cyc);
    n_cmp++; if (cyc != 48) begin n_bad++; $display("FAIL zero_latency: got %0d want 48", cyc); end
    n_cmp++; if (bus.W !== '0) begin n_bad++; $display("FAIL zero_sched: word %0d got %h want 0", first_diff(bus.W, '0), bus.W[first_diff(bus.W, '0)]); end
    handoff();
  endtask

  task automatic test_hold_stall();
    blk_t b1, b2;
    sched_t want;
    int cyc;
    b1 = rand_blk();
    b2 = rand_blk();
    want = model(b1);
    accept_block(b1);
    wait_hold(cyc);
    n_cmp++; if (cyc != 48) begin n_bad++; $display("FAIL stall_latency: got %0d want 48", cyc); end
    bus.block_in = b2;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (bus.W !== want || bus.w_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_cycle%0d: w_valid=%b in_ready=%b busy=%b first bad word %0d", i, bus.w_valid, bus.in_ready, bus.busy, first_diff(bus.W, want));
      end
    end
    handoff();
    n_cmp++; if (bus.w_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL stall_handoff_only: w_valid=%b in_ready=%b busy=%b want 0/1/0", bus.w_valid, bus.in_ready, bus.busy); end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1 || bus.W[0:15] !== b2) begin n_bad++; $display("FAIL stall_next_accept: busy=%b W0=%h want 1/%h", bus.busy, bus.W[0], b2[0]); end
    want = model(b2);
    wait_hold(cyc);
    n_cmp++; if (cyc != 48 || bus.W !== want) begin n_bad++; $display("FAIL stall_second_sched: latency %0d want 48, first bad word %0d", cyc, first_diff(bus.W, want)); end
    handoff();
  endtask

  task automatic test_reset_mid();
    sched_t want;
    int cyc;
    accept_block(abc_blk());
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.block_in = rand_blk();
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.w_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags: in_ready=%b busy=%b w_valid=%b want 1/0/0", bus.in_ready, bus.busy, bus.w_valid); end
    n_cmp++; if (bus.W !== '0) begin n_bad++; $display("FAIL mid_reset_W: word %0d got %h want 0", first_diff(bus.W, '0), bus.W[first_diff(bus.W, '0)]); end
    want = model(abc_blk());
    accept_block(abc_blk());
    wait_hold(cyc);
    n_cmp++; if (cyc != 48) begin n_bad++; $display("FAIL mid_relatency: got %0d want 48", cyc); end
    n_cmp++; if (bus.W[63] !== 32'h12B1EDEB || bus.W !== want) begin n_bad++; $display("FAIL mid_resched: W63 got %h want 12b1edeb, first bad word %0d", bus.W[63], first_diff(bus.W, want)); end
    handoff();
  endtask

  task automatic test_back_to_back();
    sched_t q[$];
    sched_t want;
    blk_t b;
    logic rdy;
    int cyc, last_acc, acc_cnt, done;
    cyc = 0; last_acc = -1; acc_cnt = 0; done = 0;
    b = rand_blk();
    bus.block_in = b;
    bus.in_valid = 1'b1;
    bus.w_ready  = 1'b1;
    while (done < 1000 && cyc < 1000 * 50 + 500) begin
      rdy = bus.in_ready;
      tick();
      cyc++;
      if (rdy === 1'b1 && acc_cnt < 1000) begin
        q.push_back(model(b));
        if (last_acc >= 0) begin
          n_cmp++; if (cyc - last_acc != 50) begin n_bad++; $display("FAIL b2b_interval: got %0d want 50", cyc - last_acc); end
        end
        last_acc = cyc;
        acc_cnt++;
        b = rand_blk();
        bus.block_in = b;
        if (acc_cnt == 1000) bus.in_valid = 1'b0;
      end
      if (bus.w_valid === 1'b1) begin
        want = (q.size() > 0) ? q.pop_front() : '0;
        n_cmp++; if (bus.W !== want) begin n_bad++; $display("FAIL b2b_sched%0d: first bad word %0d got %h want %h", done, first_diff(bus.W, want), bus.W[first_diff(bus.W, want)], want[first_diff(bus.W, want)]); end
        done++;
      end
    end
    n_cmp++; if (done != 1000) begin n_bad++; $display("FAIL b2b_timeout: got %0d schedules want 1000", done); end
    tick();
    bus.w_ready  = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.w_ready  = 1'b0;
    bus.block_in = '0;
    test_reset();
    test_abc();
    test_zero();
    test_hold_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
